// File: rtl/hdmi_pattern_gen.sv
// Test-pattern source for an HDMI pixel pipeline: split, colour bars, checker and gradient.
// Optional build macro PATTERN_SCROLL_EN makes the checker and gradient scroll with frame_cnt.
module hdmi_pattern_gen #(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int SPLIT_LINE = 360,
  parameter int CHECK_LOG2 = 5,
  parameter int CW         = 8
) (
  input  logic          pixclk,
  input  logic          reset,
  input  logic          de,
  input  logic          sof,
  input  logic [1:0]    mode,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue,
  output logic [1:0]    mode_active,
  output logic [7:0]    frame_cnt
);

  localparam int          BAR_W    = H_ACTIVE / 8;
  localparam logic [15:0] X_LAST   = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE - 1);
  localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);
  localparam logic [15:0] SPLIT    = 16'(SPLIT_LINE);
  localparam logic [15:0] CHK_MASK = 16'(1) << CHECK_LOG2;
  localparam logic [3:0]  BAR_PAST = 4'd8;

  logic [15:0]   x, y, bar_pos;
  logic [3:0]    bar_idx;
  logic [15:0]   px, py, pbar_pos;
  logic [3:0]    pbar_idx;
  logic [15:0]   x_nxt, y_nxt, bar_pos_nxt;
  logic [3:0]    bar_idx_nxt;
  logic          at_origin, eof, chk;
  logic [1:0]    cur_mode;
  logic [15:0]   offset;
  logic [2:0]    bar_rgb;
  logic [CW-1:0] r_nxt, g_nxt, b_nxt;

`ifdef PATTERN_SCROLL_EN
  assign offset = {8'd0, frame_cnt};
`else
  assign offset = '0;
`endif

  // Pixel being rendered this cycle: sof forces (0,0) regardless of counter state.
  always_comb begin
    px        = sof ? '0 : x;
    py        = sof ? '0 : y;
    pbar_pos  = sof ? '0 : bar_pos;
    pbar_idx  = sof ? '0 : bar_idx;
    at_origin = sof || (x == '0 && y == '0);
    eof       = (x == X_LAST) && (y == Y_LAST);
    cur_mode  = at_origin ? mode : mode_active;

    x_nxt       = px + 16'd1;
    y_nxt       = py;
    bar_pos_nxt = pbar_pos + 16'd1;
    bar_idx_nxt = pbar_idx;
    if (px == X_LAST) begin
      x_nxt       = '0;
      bar_pos_nxt = '0;
      bar_idx_nxt = '0;
      y_nxt       = (py == Y_LAST) ? '0 : py + 16'd1;
    end else if (pbar_pos == BAR_LAST && pbar_idx != BAR_PAST) begin
      bar_pos_nxt = '0;
      bar_idx_nxt = pbar_idx + 4'd1;
    end
  end

  // Bar index 8 covers the remainder pixels past the last full bar.
  always_comb begin
    case (pbar_idx)
      4'd0:    bar_rgb = 3'b111;
      4'd1:    bar_rgb = 3'b110;
      4'd2:    bar_rgb = 3'b011;
      4'd3:    bar_rgb = 3'b010;
      4'd4:    bar_rgb = 3'b101;
      4'd5:    bar_rgb = 3'b100;
      4'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  always_comb begin
    r_nxt = '0;
    g_nxt = '0;
    b_nxt = '0;
    chk   = |((px ^ (py + offset)) & CHK_MASK);
    case (cur_mode)
      2'd0: begin
        if (py < SPLIT) r_nxt = '1;
        else            b_nxt = '1;
      end
      2'd1: begin
        r_nxt = {CW{bar_rgb[2]}};
        g_nxt = {CW{bar_rgb[1]}};
        b_nxt = {CW{bar_rgb[0]}};
      end
      2'd2: begin
        if (chk) begin
          r_nxt = '1;
          g_nxt = '1;
          b_nxt = '1;
        end
      end
      default: begin
        r_nxt = px[CW-1:0] + offset[CW-1:0];
        g_nxt = py[CW-1:0];
        b_nxt = ~(px[CW-1:0] + offset[CW-1:0]);
      end
    endcase
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      bar_pos     <= '0;
      bar_idx     <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      mode_active <= '0;
      frame_cnt   <= '0;
    end else if (de) begin
      x       <= x_nxt;
      y       <= y_nxt;
      bar_pos <= bar_pos_nxt;
      bar_idx <= bar_idx_nxt;
      red     <= r_nxt;
      green   <= g_nxt;
      blue    <= b_nxt;
      if (at_origin) mode_active <= mode;
      if (eof) frame_cnt <= frame_cnt + 8'd1;
    end else begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end
  end

endmodule

// File: doc/hdmi_pattern_gen.md
HDMI_PATTERN_GEN -- requirements
Module: hdmi_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 SHALL have parameter SPLIT_LINE, default 360, first line of the lower field in split mode.
REQ-004 SHALL have parameter CHECK_LOG2, default 5, log2 of checker square size in pixels.
REQ-005 SHALL have parameter CW, default 8, bits per colour channel.
REQ-006 SHALL have port pixclk, input, 1, pixel clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port de, input, 1, data enable; high for each active pixel.
REQ-009 SHALL have port sof, input, 1, start of frame; qualified by de, marks pixel (0,0).
REQ-010 SHALL have port mode, input, 2, requested pattern mode.
REQ-011 SHALL have port red, output, CW, red channel.
REQ-012 SHALL have port green, output, CW, green channel.
REQ-013 SHALL have port blue, output, CW, blue channel.
REQ-014 SHALL have port mode_active, output, 2, mode used for the current frame.
REQ-015 SHALL have port frame_cnt, output, 8, completed-frame counter.

Function
REQ-016 SHALL hold internal x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) counters, advanced only on cycles with de=1.
REQ-017 x SHALL wrap from H_ACTIVE-1 to 0 and increment y; y SHALL wrap from V_ACTIVE-1 to 0 (end of frame).
REQ-018 de=1 with sof=1 SHALL treat the current pixel as (0,0), whatever the counter state; this resynchronises x and y.
REQ-019 mode SHALL be sampled into mode_active only at end of frame or on de&sof; mid-frame changes SHALL have no effect until the next frame.
REQ-020 RGB SHALL be registered, with latency one pixclk from the de cycle of the pixel.
REQ-021 The cycle after de=0 SHALL output RGB = 0.
REQ-022 Mode 0 (split): y<SPLIT_LINE SHALL give red = all ones, others 0; otherwise blue = all ones, others 0.
REQ-023 Mode 1 (bars): eight bars of width H_ACTIVE/8, tracked by an incremental bar counter with no divider.
REQ-024 Mode 1 bar order SHALL be white, yellow, cyan, green, magenta, red, blue, black; channels SHALL be all-ones or 0.
REQ-025 Any remainder pixels past 8*(H_ACTIVE/8) SHALL show black.
REQ-026 Mode 2 (checker): pixel is white when bit CHECK_LOG2 of x XOR bit CHECK_LOG2 of (y+offset) is 1, else black.
REQ-027 Mode 2 offset SHALL be 0 unless scrolling is enabled (REQ-033).
REQ-028 Mode 3 (gradient): red = x[CW-1:0]+offset (mod 2^CW), green = y[CW-1:0], blue = ~red.
REQ-029 frame_cnt SHALL increment by 1 at each end of frame and wrap 255 to 0.
REQ-030 A de&sof resync SHALL NOT increment frame_cnt unless it coincides with a natural end of frame.

Reset
REQ-031 Reset SHALL clear x, y, the bar counter, red, green, blue, mode_active and frame_cnt to 0.
REQ-032 Reset SHALL dominate de and sof in the same cycle; the first de cycle after reset SHALL be pixel (0,0), mode_active = mode.

Configuration
REQ-033 With PATTERN_SCROLL_EN defined, offset SHALL equal frame_cnt, so mode 2 scrolls one line per frame and mode 3 one code per frame.
REQ-034 With PATTERN_SCROLL_EN undefined, offset SHALL be constant 0.
REQ-035 With PATTERN_SCROLL_EN undefined, modes 0 and 1 SHALL be unaffected and frame_cnt SHALL still count.

Verification
REQ-036 Reset, mode=0, full 1280x720 frame with sof on first pixel -> line 359 is red=255,g=0,b=0; line 360 is blue=255; frame_cnt=1.
REQ-037 Mode=1, one line -> x=0..159 white, x=160 yellow, x=1120..1279 black; output lags de by 1 cycle.
REQ-038 Mode switched 0->2 at line 100 -> rest of frame stays split; next frame is checker, with (0,0) black and (32,0) white.
REQ-039 de&sof pulsed at x=500,y=10 -> that pixel renders as (0,0); frame_cnt is unchanged.
REQ-040 PATTERN_SCROLL_EN defined, mode=3, three frames -> pixel (0,0) red = 0, 1, 2 and blue = 255, 254, 253; macro undefined -> red = 0 each frame.
REQ-041 Reset asserted mid-line with de=1 -> next cycle RGB=0 and frame_cnt=0; counting restarts at (0,0).
